// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its frame sequencer.
//   MODE_*  : usr.mode encodings (hold / shift right / shift left / parallel load)
//   state_t : sequencer state encoding
package usr_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/usr.sv
// 4-bit universal shift register datapath.
//   clk     in  clock, rising edge
//   rst     in  asynchronous active-high reset, clears the register
//   mode    in  00 hold, 01 shift right (s_data -> MSB), 10 shift left (s_data -> LSB), 11 load
//   p_in    in  parallel load word
//   s_data  in  serial input bit
//   p_out   out register contents
//   r_out   out bit leaving on a right shift (LSB)
//   l_out   out bit leaving on a left shift (MSB)
module usr
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [3:0] p_in,
    input  logic       s_data,
    output logic [3:0] p_out,
    output logic       r_out,
    output logic       l_out
);

    logic [3:0] p_q;
    logic [3:0] p_d;

    always_comb begin
        p_d = p_q;
        case (mode)
            MODE_RIGHT: p_d = {s_data, p_q[3:1]};
            MODE_LEFT:  p_d = {p_q[2:0], s_data};
            MODE_LOAD:  p_d = p_in;
            default:    p_d = p_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_q <= '0;
        else     p_q <= p_d;
    end

    assign p_out = p_q;
    assign r_out = p_q[0];
    assign l_out = p_q[3];

endmodule

// File: rtl/usr_seq_ctrl.sv
// Frame sequencer for the usr: accepts a parallel word (valid/ready), loads it,
// shifts it out serially while shifting ser_in in, then offers the received word.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data : producer handshake, in_dir selects shift direction
//   ser_in/ser_out/ser_en     : 1-bit link; ser_en high in every SHIFT clock
//   out_valid/out_ready/out_data : consumer handshake carrying usr.p_out
//   busy                      : high in any state except IDLE
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for in_valid; in_ready high
// ST_LOAD  | one clock, parallel-load captured word into usr
// ST_SHIFT | one shift per prescaler tick until SHIFT_CNT shifts done
// ST_DONE  | received word presented until out_ready
// ST_GAP   | IDLE_GAP idle clocks before accepting the next word
module usr_seq_ctrl
    import usr_pkg::*;
#(
    parameter int SHIFT_CNT = 4,
    parameter int PRESC     = 0,
    parameter int IDLE_GAP  = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_dir,
    input  logic       ser_in,
    output logic       ser_out,
    output logic       ser_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       busy
);

    localparam logic [3:0] LAST_BIT  = 4'(SHIFT_CNT - 1);
    localparam logic [7:0] PRESC_MAX = 8'(PRESC);
    localparam logic [3:0] LAST_GAP  = 4'(IDLE_GAP - 1);
    localparam bit         HAS_GAP   = (IDLE_GAP > 0);

    state_t     state_q,     state_d;
    logic [3:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] presc_cnt_q, presc_cnt_d;
    logic [3:0] gap_cnt_q,   gap_cnt_d;
    logic [3:0] data_q,      data_d;
    logic       dir_q,       dir_d;

    logic       tick;
    logic [1:0] usr_mode;
    logic [3:0] usr_p_out;
    logic       usr_r_out;
    logic       usr_l_out;

    assign tick = (state_q == ST_SHIFT) && (presc_cnt_q == PRESC_MAX);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        presc_cnt_d = presc_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        data_d      = data_q;
        dir_d       = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    dir_d   = in_dir;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bit_cnt_d   = '0;
                presc_cnt_d = '0;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    presc_cnt_d = '0;
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) state_d = ST_DONE;
                end else begin
                    presc_cnt_d = presc_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    gap_cnt_d = '0;
                    state_d   = HAS_GAP ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == LAST_GAP) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            presc_cnt_q <= '0;
            gap_cnt_q   <= '0;
            data_q      <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            presc_cnt_q <= presc_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            data_q      <= data_d;
            dir_q       <= dir_d;
        end
    end

    // usr only moves on the load clock and on prescaler ticks; otherwise it holds.
    always_comb begin
        usr_mode = MODE_HOLD;
        case (state_q)
            ST_LOAD:  usr_mode = MODE_LOAD;
            ST_SHIFT: usr_mode = tick ? (dir_q ? MODE_LEFT : MODE_RIGHT) : MODE_HOLD;
            default:  usr_mode = MODE_HOLD;
        endcase
    end

    usr u_usr (
        .clk    (clk),
        .rst    (~rst_n),
        .mode   (usr_mode),
        .p_in   (data_q),
        .s_data (ser_in),
        .p_out  (usr_p_out),
        .r_out  (usr_r_out),
        .l_out  (usr_l_out)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign ser_en    = (state_q == ST_SHIFT);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = usr_p_out;
    assign ser_out   = dir_q ? usr_l_out : usr_r_out;

endmodule
